branch_predictor: RTL and testbench

Dynamic branch predictor for the five-stage RV64 pipeline, parametrised in table depth, counter width and tag width. Fetch looks up the current PC and receives a direction and target prediction. Decode reports each resolved control-flow instruction back. The block compares the outcome with the prediction carried down the pipe, raises a redirect on mismatch, and trains its table. On reset it sweeps and clears the table with an internal init state machine before accepting traffic.

---
 rtl/branch_predictor_pkg.sv | 39 +++
 rtl/branch_predictor_sat_counter.sv | 30 +++
 rtl/branch_predictor.sv | 182 ++++++++++++++++++
 tb/tb_branch_predictor.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// Package pipes
// Shared types for the branch predictor:
//   bp_kind_t  - kind of control-flow instruction (conditional, JAL, JALR)
//   bp_state_t - init sweep / run state of the predictor table
//   bp_entry_t - one predictor table entry
// Default values of the predictor parameters are also kept here.
// -----------------------------------------------------------------------------
package pipes;

    localparam int BP_ENTRIES_DEF = 64;
    localparam int BP_CNT_W_DEF   = 2;
    localparam int BP_TAG_W_DEF   = 8;

    // Largest legal tag and counter widths. Entry fields are sized to these
    // maxima; a narrower configuration keeps the upper bits at zero.
    localparam int BP_TAG_W_MAX   = 16;
    localparam int BP_CNT_W_MAX   = 4;

    typedef enum logic [1:0] {
        BK_COND = 2'd0,
        BK_JAL  = 2'd1,
        BK_JALR = 2'd2
    } bp_kind_t;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_t;

    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_W_MAX-1:0] tag;
        bp_kind_t                kind;
        logic [63:0]             target;
        logic [BP_CNT_W_MAX-1:0] cnt;
    } bp_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Combinational next value of a saturating up/down counter. It holds no
// state; the current value comes from the predictor table.
//   cnt_i  in  CNT_W : current counter value
//   inc_i  in  1     : count up (stops at all ones)
//   dec_i  in  1     : count down (stops at zero)
//   cnt_o  out CNT_W : next counter value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o
);

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        cnt_o = cnt_i;
        if (inc_i && !dec_i && (cnt_i != '1)) begin
            cnt_o = cnt_i + CNT_W'(1);
        end else if (dec_i && !inc_i && (cnt_i != '0)) begin
            cnt_o = cnt_i - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped dynamic branch predictor with partial tags, saturating
// direction counters and stored targets. After reset an init sweep clears
// one entry per cycle; ready rises when the sweep is done.
//   clk, reset (async, active low)
//   ready                       : init sweep complete
//   pc_f -> pred_taken, pred_target         : fetch lookup (combinational)
//   upd_valid, upd_pc, upd_kind, upd_taken, upd_target,
//   upd_pred_taken, upd_pred_target         : resolved branch from decode
//   mispredict, redirect_pc                 : redirect to fetch (combinational)
// Optional build macro BP_STATS_EN adds stat_branches / stat_mispredicts,
// 32-bit saturating counters of resolved branches and mispredicts in RUN.
// -----------------------------------------------------------------------------
module branch_predictor
    import pipes::*;
#(
    parameter int ENTRIES = BP_ENTRIES_DEF,
    parameter int CNT_W   = BP_CNT_W_DEF,
    parameter int TAG_W   = BP_TAG_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready,
    input  logic [63:0] pc_f,
    output logic        pred_taken,
    output logic [63:0] pred_target,
    input  logic        upd_valid,
    input  logic [63:0] upd_pc,
    input  bp_kind_t    upd_kind,
    input  logic        upd_taken,
    input  logic [63:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [63:0] upd_pred_target,
    output logic        mispredict,
    output logic [63:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    // Weak-not-taken: MSB 0, rest 1. Weak-taken: MSB 1, rest 0.
    localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};

    bp_state_t        state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    bp_entry_t        table_q [ENTRIES];

    logic             run;
    logic [IDX_W-1:0] lk_idx, up_idx, wr_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic [CNT_W-1:0] cnt_next;
    logic             wr_en;
    bp_entry_t        wr_entry;

    assign run   = (state_q == BP_RUN);
    assign ready = run;

    assign lk_idx = pc_f[IDX_W+1:2];
    assign lk_tag = pc_f[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Table contents are meaningless until the sweep finishes, so hits are
    // only reported in RUN.
    assign lk_hit = run && table_q[lk_idx].valid
                    && (table_q[lk_idx].tag == BP_TAG_W_MAX'(lk_tag));
    assign up_hit = run && table_q[up_idx].valid
                    && (table_q[up_idx].tag == BP_TAG_W_MAX'(up_tag));

    // ---------------------------------------------------------------- lookup
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc_f + 64'd4;
        if (lk_hit && ((table_q[lk_idx].kind != BK_COND)
                       || table_q[lk_idx].cnt[CNT_W-1])) begin
            pred_taken  = 1'b1;
            pred_target = table_q[lk_idx].target;
        end
    end

    // ------------------------------------------------------------ mispredict
    assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken)
                         || (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : (upd_pc + 64'd4);

    // -------------------------------------------------------------- training
    sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
        .cnt_i (table_q[up_idx].cnt[CNT_W-1:0]),
        .inc_i (upd_taken),
        .dec_i (!upd_taken),
        .cnt_o (cnt_next)
    );

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = init_idx_q;
        wr_entry = '0;
        if (state_q == BP_INIT) begin
            wr_en        = 1'b1;
            wr_entry.cnt = BP_CNT_W_MAX'(CNT_WNT);
        end else if (upd_valid) begin
            wr_idx = up_idx;
            if (up_hit) begin
                wr_en        = 1'b1;
                wr_entry     = table_q[up_idx];
                wr_entry.cnt = BP_CNT_W_MAX'(cnt_next);
                if (upd_taken) begin
                    wr_entry.kind   = upd_kind;
                    wr_entry.target = upd_target;
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever aliases to this index.
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = BP_TAG_W_MAX'(up_tag);
                wr_entry.kind   = upd_kind;
                wr_entry.target = upd_target;
                wr_entry.cnt    = BP_CNT_W_MAX'(CNT_WT);
            end
        end
    end

    // NOTE: the table has no reset branch; the init sweep clears it, which
    // keeps the array a plain synchronous-write memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_idx] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------- FSM
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == BP_INIT) begin
            init_idx_d = init_idx_q + IDX_W'(1);
            if (init_idx_q == IDX_W'(ENTRIES - 1)) begin
                state_d = BP_RUN;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BP_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (run) begin
            if (upd_valid && (stat_br_q != '1)) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (mispredict && (stat_mp_q != '1)) begin
                stat_mp_q <= stat_mp_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Scoreboard bench: each cycle the driver applies inputs, derives the expected
// outputs from a table model kept in plain arrays, and queues them; a monitor
// pops one entry per falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_branch_predictor;
    import pipes::*;

    localparam int ENTRIES = 64;
    localparam int CNT_W   = 2;
    localparam int TAG_W   = 8;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int CNT_HALF = 1 << (CNT_W - 1);

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic [63:0] pc_f;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        upd_valid;
    logic [63:0] upd_pc;
    bp_kind_t    upd_kind;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        upd_pred_taken;
    logic [63:0] upd_pred_target;
    logic        mispredict;
    logic [63:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .TAG_W(TAG_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .ready           (ready),
        .pc_f            (pc_f),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_kind        (upd_kind),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        bit          rdy;
        bit          pt;
        logic [63:0] ptgt;
        bit          mp;
        logic [63:0] rpc;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ready",       64'(ready),       64'(e.rdy));
                check("pred_taken",  64'(pred_taken),  64'(e.pt));
                check("pred_target", pred_target,      e.ptgt);
                check("mispredict",  64'(mispredict),  64'(e.mp));
                check("redirect_pc", redirect_pc,      e.rpc);
`ifdef BP_STATS_EN
                check("stat_branches",    64'(stat_branches),    64'(e.sb));
                check("stat_mispredicts", 64'(stat_mispredicts), 64'(e.sm));
`endif
            end
        end
    end

    // ------------------------------------------------------- reference model
    // Table modelled as arrays of plain integers; the sweep is modelled as a
    // count of entries already cleared since reset was released.
    bit          m_valid [ENTRIES];
    int          m_tag   [ENTRIES];
    int          m_kind  [ENTRIES];
    logic [63:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    int          m_swept = 0;
    logic [31:0] m_sb = '0;
    logic [31:0] m_sm = '0;

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 2) % 64'(ENTRIES));
    endfunction

    function automatic int tag_of(input logic [63:0] pc);
        return int'((pc >> (IDX_W + 2)) % (64'd1 << TAG_W));
    endfunction

    function automatic void model_lookup(input logic [63:0] pc, output bit t,
                                         output logic [63:0] tgt);
        int i;
        i   = idx_of(pc);
        t   = 1'b0;
        tgt = pc + 64'd4;
        if (m_swept == ENTRIES && m_valid[i] && m_tag[i] == tag_of(pc)) begin
            if (m_kind[i] != int'(BK_COND) || m_cnt[i] >= CNT_HALF) begin
                t   = 1'b1;
                tgt = m_tgt[i];
            end
        end
    endfunction

    task automatic step(input bit rst_v, input logic [63:0] lpc, input bit uv,
                        input logic [63:0] upc, input bp_kind_t uk, input bit ut,
                        input logic [63:0] utgt, input bit upt,
                        input logic [63:0] uptgt);
        exp_t e;
        bit   mp;
        int   i;
        reset           = rst_v;
        pc_f            = lpc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_kind        = uk;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;
        if (!rst_v) begin
            m_swept = 0;
            m_sb    = '0;
            m_sm    = '0;
        end
        model_lookup(lpc, e.pt, e.ptgt);
        mp    = uv && ((ut != upt) || (ut && utgt != uptgt));
        e.mp  = mp;
        e.rpc = ut ? utgt : upc + 64'd4;
        e.rdy = (m_swept == ENTRIES);
        e.sb  = m_sb;
        e.sm  = m_sm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst_v) begin
            if (m_swept < ENTRIES) begin
                m_valid[m_swept] = 1'b0;
                m_cnt[m_swept]   = CNT_HALF - 1;
                m_swept++;
            end else if (uv) begin
                if (m_sb != 32'hFFFF_FFFF) m_sb++;
                if (mp && m_sm != 32'hFFFF_FFFF) m_sm++;
                i = idx_of(upc);
                if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
                    m_cnt[i] = ut ? ((m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX)
                                  : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
                    if (ut) begin
                        m_kind[i] = int'(uk);
                        m_tgt[i]  = utgt;
                    end
                end else if (ut) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = tag_of(upc);
                    m_kind[i]  = int'(uk);
                    m_tgt[i]   = utgt;
                    m_cnt[i]   = CNT_HALF;
                end
            end
        end
    endtask

    task automatic look(input logic [63:0] lpc);
        step(1'b1, lpc, 1'b0, 64'd0, BK_COND, 1'b0, 64'd0, 1'b0, 64'd0);
    endtask

    // Resolve a branch using the prediction fetch would have made for it.
    task automatic resolve(input logic [63:0] lpc, input logic [63:0] upc,
                           input bp_kind_t uk, input bit ut,
                           input logic [63:0] utgt);
        bit          pt;
        logic [63:0] ptgt;
        model_lookup(upc, pt, ptgt);
        step(1'b1, lpc, 1'b1, upc, uk, ut, utgt, pt, ptgt);
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        bp_kind_t    k;
        bit          t, pt;
        logic [63:0] upc, lpc, tgt, ptgt;

        reset = 1'b0; pc_f = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_kind = BK_COND; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;
        @(posedge clk);
        #1;

        // Under reset: default prediction, mispredict still live.
        step(1'b0, 64'h8000_0000, 1'b1, 64'h8000_0010, BK_COND, 1'b1,
             64'h8000_0100, 1'b0, 64'h8000_0014);
        step(1'b0, 64'h8000_0000, 1'b1, 64'h8000_0010, BK_COND, 1'b0,
             64'h0, 1'b1, 64'h8000_0100);

        // Sweep: ready low for ENTRIES samples, updates must not train.
        for (int n = 0; n < ENTRIES; n++) begin
            if (n % 8 == 0)
                step(1'b1, 64'h8000_0000, 1'b1, 64'h8000_0020, BK_JAL, 1'b1,
                     64'h8000_0800, 1'b0, 64'h8000_0024);
            else
                look(64'h8000_0000);
        end
        look(64'h8000_0020);

        // Cold conditional, then three not-taken resolutions.
        resolve(64'h8000_0010, 64'h8000_0010, BK_COND, 1'b1, 64'h8000_0100);
        look(64'h8000_0010);
        for (int n = 0; n < 3; n++)
            resolve(64'h8000_0010, 64'h8000_0010, BK_COND, 1'b0, 64'h0);
        look(64'h8000_0010);

        // JALR retargeted.
        resolve(64'h8000_0020, 64'h8000_0020, BK_JALR, 1'b1, 64'h8000_0200);
        resolve(64'h8000_0020, 64'h8000_0020, BK_JALR, 1'b1, 64'h8000_0300);
        look(64'h8000_0020);

        // Aliasing: retrain 0x..0010 taken, then evict with 0x..1010.
        resolve(64'h8000_0010, 64'h8000_0010, BK_COND, 1'b1, 64'h8000_0100);
        resolve(64'h8000_0010, 64'h8000_0010, BK_COND, 1'b1, 64'h8000_0100);
        look(64'h8000_0010);
        resolve(64'h8000_0010, 64'h8000_1010, BK_COND, 1'b1, 64'h8000_0180);
        look(64'h8000_0010);
        look(64'h8000_1010);

        // Upper saturation, then one step down keeps it taken.
        for (int n = 0; n < 5; n++)
            resolve(64'h8000_0040, 64'h8000_0040, BK_COND, 1'b1, 64'h8000_0400);
        resolve(64'h8000_0040, 64'h8000_0040, BK_COND, 1'b0, 64'h0);
        look(64'h8000_0040);

        // +4 wrap-around on both lookup and redirect.
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC,
             BK_COND, 1'b0, 64'h0, 1'b1, 64'h1234);

        // Random traffic over a small PC pool with aliasing.
        for (int n = 0; n < 400; n++) begin
            upc = 64'h8000_0000 + 64'(4 * $urandom_range(0, 15))
                  + (64'($urandom_range(0, 3)) << 12);
            lpc = ($urandom_range(0, 2) == 0) ? upc
                  : 64'h8000_0000 + 64'(4 * $urandom_range(0, 15))
                    + (64'($urandom_range(0, 3)) << 12);
            k   = bp_kind_t'($urandom_range(0, 2));
            t   = (k != BK_COND) ? 1'b1 : 1'($urandom_range(0, 1));
            tgt = 64'h8000_4000 + 64'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                model_lookup(upc, pt, ptgt);
            end else begin
                pt   = 1'($urandom_range(0, 1));
                ptgt = 64'h8000_4000 + 64'(4 * $urandom_range(0, 7));
            end
            step(1'b1, lpc, 1'($urandom_range(0, 4) != 0), upc, k, t, tgt, pt, ptgt);
        end

        // Reset pulsed 20 cycles into a sweep.
        step(1'b0, 64'h8000_0010, 1'b0, 64'h0, BK_COND, 1'b0, 64'h0, 1'b0, 64'h0);
        for (int n = 0; n < 20; n++) look(64'h8000_0010);
        step(1'b0, 64'h8000_0010, 1'b0, 64'h0, BK_COND, 1'b0, 64'h0, 1'b0, 64'h0);
        for (int n = 0; n < ENTRIES + 1; n++) look(64'h8000_0020);
        look(64'h8000_0040);
        look(64'h8000_1010);

        for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
